// File: rtl/axi_ar_norm_arb_pkg.sv
// Widths, FSM state type and the address-normalization helper for the AR arbiter.
`include "axi_defines.vh"

package axi_ar_norm_arb_pkg;

  localparam int ADDR_W = `AXI4_ADDR_WIDTH;
  localparam int ID_W   = `AXI4_ID_WIDTH;
  localparam int LEN_W  = `AXI4_LEN_WIDTH;
  localparam int DATA_W = `AXI4_DATA_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Node bits move into the destination field; the old destination bits are dropped.
  function automatic logic [ADDR_W-1:0] norm_addr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] res;
    res = addr;
    res[`AXI4_NODE_DST_HI:`AXI4_NODE_DST_LO] = addr[`AXI4_NODE_HI:`AXI4_NODE_LO];
    return res;
  endfunction

endpackage

// File: rtl/axi_ar_norm_arb_if.sv
// Upstream AR/R requester bundle plus the shared downstream read port of the arbiter.
interface axi_ar_norm_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  import axi_ar_norm_arb_pkg::*;

  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*ID_W-1:0]   s_arid;
  logic [NUM_REQ*LEN_W-1:0]  s_arlen;

  logic                      m_arvalid;
  logic                      m_arready;
  logic [ADDR_W-1:0]         m_araddr;
  logic [ID_W+IDX_W-1:0]     m_arid;
  logic [LEN_W-1:0]          m_arlen;

  logic                      m_rvalid;
  logic                      m_rready;
  logic [ID_W+IDX_W-1:0]     m_rid;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;

  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;
  logic [ID_W-1:0]           s_rid;
  logic [DATA_W-1:0]         s_rdata;
  logic [1:0]                s_rresp;
  logic                      s_rlast;

  logic                      bad_rid;

  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, m_arready,
           m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, s_rready,
    output s_arready, m_arvalid, m_araddr, m_arid, m_arlen,
           m_rready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, bad_rid
  );

  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, m_arready,
           m_rvalid, m_rid, m_rdata, m_rresp, m_rlast, s_rready,
    input  s_arready, m_arvalid, m_araddr, m_arid, m_arlen,
           m_rready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, bad_rid
  );

endinterface

// File: rtl/axi_ar_norm_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module axi_ar_norm_arb_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  int  best_off_s;
  int  off_s;
  logic take_s;

  // Keep the requester with the smallest rotational distance from the pointer
  always_comb begin
    gnt_idx_o  = '0;
    gnt_vld_o  = |req_i;
    best_off_s = NUM_REQ;
    off_s      = 0;
    take_s     = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off_s      = (j >= int'(ptr_i)) ? (j - int'(ptr_i)) : (j + NUM_REQ - int'(ptr_i));
      take_s     = req_i[j] && (off_s < best_off_s);
      gnt_idx_o  = take_s ? IDX_W'(j) : gnt_idx_o;
      best_off_s = take_s ? off_s : best_off_s;
    end
  end

endmodule

// File: rtl/axi_defines.vh
// Shared AXI4 widths and the node-field locations used by every address-normalization site.
`ifndef AXI_DEFINES_VH
`define AXI_DEFINES_VH

`define AXI4_ADDR_WIDTH  64
`define AXI4_ID_WIDTH    16
`define AXI4_LEN_WIDTH   8
`define AXI4_DATA_WIDTH  64

`define AXI4_NODE_LO     16
`define AXI4_NODE_HI     20
`define AXI4_NODE_DST_LO 44
`define AXI4_NODE_DST_HI 48

`endif

// File: rtl/axi_ar_norm_arb.sv
// Round-robin AR arbiter with address normalization, ID extension, R routing and per-source throttling.
module axi_ar_norm_arb
  import axi_ar_norm_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_OUTST = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  axi_ar_norm_arb_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_vld_s;
  logic               ar_load_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] arready_s;

  logic [ADDR_W-1:0]  sel_addr_s;
  logic [ID_W-1:0]    sel_id_s;
  logic [LEN_W-1:0]   sel_len_s;

  logic               m_arvalid_q;
  logic [ADDR_W-1:0]  m_araddr_q;
  logic [ID_W+IDX_W-1:0] m_arid_q;
  logic [LEN_W-1:0]   m_arlen_q;

  logic [IDX_W-1:0]   r_idx_s;
  logic               r_idx_ok_s;
  logic [NUM_REQ-1:0] rvalid_s;
  logic [NUM_REQ-1:0] dec_s;
  logic               mrready_s;
  logic               bad_rid_q;

  logic [CNT_W-1:0]   outst_q [NUM_REQ];

  // Eligibility and slice selection for the picked requester
  always_comb begin
    elig_s     = '0;
    sel_addr_s = '0;
    sel_id_s   = '0;
    sel_len_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i]  = bus.s_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
      sel_addr_s = (pick_idx_s == IDX_W'(i)) ? bus.s_araddr[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_id_s   = (pick_idx_s == IDX_W'(i)) ? bus.s_arid[i*ID_W +: ID_W]       : sel_id_s;
      sel_len_s  = (pick_idx_s == IDX_W'(i)) ? bus.s_arlen[i*LEN_W +: LEN_W]    : sel_len_s;
    end
  end

  axi_ar_norm_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i     (elig_s),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx_s),
    .gnt_vld_o (pick_vld_s)
  );

  // Arbitration FSM: accept in IDLE, hold the master AR until it is taken
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    ar_load_s = 1'b0;
    arready_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s) begin
          ar_load_s = 1'b1;
          gnt_d     = pick_idx_s;
          state_d   = ST_HOLD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.m_arready) begin
          rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : (gnt_q + IDX_W'(1));
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      arready_s[i] = ar_load_s && (pick_idx_s == IDX_W'(i));
    end
  end

  // FSM state, round-robin pointer and granted index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  // Master AR register slice, loaded with the normalized granted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arid_q    <= '0;
      m_arlen_q   <= '0;
    end else if (ar_load_s) begin
      m_arvalid_q <= 1'b1;
      m_araddr_q  <= norm_addr(sel_addr_s);
      m_arid_q    <= {pick_idx_s, sel_id_s};
      m_arlen_q   <= sel_len_s;
    end else if ((state_q == ST_HOLD) && bus.m_arready) begin
      m_arvalid_q <= 1'b0;
    end
  end

  assign r_idx_s = bus.m_rid[ID_W+IDX_W-1 -: IDX_W];

  // Only a non-power-of-two requester count leaves unused index codes
  generate
    if ((1 << IDX_W) == NUM_REQ) begin : g_idx_full
      assign r_idx_ok_s = 1'b1;
    end else begin : g_idx_part
      assign r_idx_ok_s = (r_idx_s < IDX_W'(NUM_REQ));
    end
  endgenerate

  // R routing by source index; beats with an unknown index are sunk
  always_comb begin
    rvalid_s  = '0;
    dec_s     = '0;
    mrready_s = !r_idx_ok_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = bus.m_rvalid && r_idx_ok_s && (r_idx_s == IDX_W'(i));
      mrready_s   = (r_idx_ok_s && (r_idx_s == IDX_W'(i))) ? bus.s_rready[i] : mrready_s;
      dec_s[i]    = rvalid_s[i] && bus.s_rready[i] && bus.m_rlast;
    end
  end

  // Per-requester outstanding burst counters; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arready_s[i] && !dec_s[i]) begin
          outst_q[i] <= outst_q[i] + CNT_W'(1);
        end else if (dec_s[i] && !arready_s[i] && (outst_q[i] != '0)) begin
          outst_q[i] <= outst_q[i] - CNT_W'(1);
        end else begin
          outst_q[i] <= outst_q[i];
        end
      end
    end
  end

  // Unknown-index beat indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_rid_q <= 1'b0;
    end else begin
      bad_rid_q <= bus.m_rvalid && !r_idx_ok_s;
    end
  end

  assign bus.s_arready = arready_s;
  assign bus.m_arvalid = m_arvalid_q;
  assign bus.m_araddr  = m_araddr_q;
  assign bus.m_arid    = m_arid_q;
  assign bus.m_arlen   = m_arlen_q;
  assign bus.m_rready  = mrready_s;
  assign bus.s_rvalid  = rvalid_s;
  assign bus.s_rid     = bus.m_rid[ID_W-1:0];
  assign bus.s_rdata   = bus.m_rdata;
  assign bus.s_rresp   = bus.m_rresp;
  assign bus.s_rlast   = bus.m_rlast;
  assign bus.bad_rid   = bad_rid_q;

endmodule

// File: tb/tb_axi_ar_norm_arb.sv
// Directed bench: instance A (4 requesters, MAX_OUTST=2) and instance B (3 requesters, MAX_OUTST=8).
module tb_axi_ar_norm_arb;
  import axi_ar_norm_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  axi_ar_norm_arb_if #(.NUM_REQ(4)) ai ();
  axi_ar_norm_arb_if #(.NUM_REQ(3)) bi ();

  axi_ar_norm_arb #(.NUM_REQ(4), .MAX_OUTST(2)) dut_a (.clk(clk), .rst(rst), .bus(ai));
  axi_ar_norm_arb #(.NUM_REQ(3), .MAX_OUTST(8)) dut_b (.clk(clk), .rst(rst), .bus(bi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ai.s_arvalid = '0; ai.s_araddr = '0; ai.s_arid = '0; ai.s_arlen = '0;
    ai.m_arready = 1'b0; ai.m_rvalid = 1'b0; ai.m_rid = '0; ai.m_rdata = '0;
    ai.m_rresp = 2'd0; ai.m_rlast = 1'b0; ai.s_rready = '0;
    bi.s_arvalid = '0; bi.s_araddr = '0; bi.s_arid = '0; bi.s_arlen = '0;
    bi.m_arready = 1'b0; bi.m_rvalid = 1'b0; bi.m_rid = '0; bi.m_rdata = '0;
    bi.m_rresp = 2'd0; bi.m_rlast = 1'b0; bi.s_rready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();

    // Reset state
    chk("rst_arvalid", 64'(ai.m_arvalid), 64'h0);
    chk("rst_araddr",  64'(ai.m_araddr),  64'h0);
    chk("rst_arid",    64'(ai.m_arid),    64'h0);
    chk("rst_arlen",   64'(ai.m_arlen),   64'h0);
    chk("rst_arready", 64'(ai.s_arready), 64'h0);
    chk("rst_badrid",  64'(bi.bad_rid),   64'h0);
    rst = 1'b0;
    tick();

    // Single AR with normalization and stall
    ai.s_arvalid = 4'b0010;
    ai.s_araddr[1*64 +: 64] = 64'h0000_1234_5678_0000;
    ai.s_arid[1*16 +: 16]   = 16'h0003;
    ai.s_arlen[1*8 +: 8]    = 8'h07;
    #1;
    chk("single_accept", 64'(ai.s_arready), 64'h2);
    tick();
    ai.s_arvalid = 4'b0000;
    chk("single_valid", 64'(ai.m_arvalid), 64'h1);
    chk("single_addr",  64'(ai.m_araddr),  64'h0001_8234_5678_0000);
    chk("single_id",    64'(ai.m_arid),    64'h1_0003);
    chk("single_len",   64'(ai.m_arlen),   64'h7);
    chk("single_noacc", 64'(ai.s_arready), 64'h0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_valid", 64'(ai.m_arvalid), 64'h1);
      chk("stall_addr",  64'(ai.m_araddr),  64'h0001_8234_5678_0000);
      chk("stall_id",    64'(ai.m_arid),    64'h1_0003);
    end
    ai.m_arready = 1'b1;
    tick();
    ai.m_arready = 1'b0;
    chk("single_drop", 64'(ai.m_arvalid), 64'h0);
    chk("single_outst1", 64'(dut_a.outst_q[1]), 64'h1);

    // Fairness: grants 0,1,2,3,0 one every two cycles
    do_reset();
    ai.s_arvalid = 4'b1111;
    ai.m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ai.s_arid[i*16 +: 16]   = 16'h00A0 + 16'(i);
      ai.s_araddr[i*64 +: 64] = 64'h1000 * 64'(i + 1);
    end
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("fair_idle_valid", 64'(ai.m_arvalid), 64'h0);
      chk("fair_accept", 64'(ai.s_arready), 64'h1 << (n % 4));
      tick();
      chk("fair_hold_valid", 64'(ai.m_arvalid), 64'h1);
      chk("fair_hold_id", 64'(ai.m_arid), (64'(n % 4) << 16) | (64'h00A0 + 64'(n % 4)));
      chk("fair_hold_noacc", 64'(ai.s_arready), 64'h0);
      tick();
      if (n == 4) begin
        ai.s_arvalid = 4'b0000;
      end else begin
        ai.s_arvalid = 4'b1111;
      end
    end

    // Throttle on requester 2 at MAX_OUTST=2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ai.s_arid[i*16 +: 16] = 16'h00A0 + 16'(i);
    end
    ai.m_arready = 1'b1;
    ai.s_arvalid = 4'b0100;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("thr_accept", 64'(ai.s_arready), 64'h4);
      tick();
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      chk("thr_blocked", 64'(ai.s_arready), 64'h0);
      chk("thr_noar", 64'(ai.m_arvalid), 64'h0);
      tick();
    end
    ai.s_arvalid = 4'b0101;
    #1;
    chk("thr_other", 64'(ai.s_arready), 64'h1);
    tick();
    chk("thr_other_id", 64'(ai.m_arid), 64'h0_00A0);
    tick();
    ai.s_arvalid = 4'b0100;
    ai.m_rvalid = 1'b1;
    ai.m_rid = {2'd2, 16'h0000};
    ai.m_rlast = 1'b1;
    ai.s_rready = 4'b0100;
    #1;
    chk("thr_rvalid", 64'(ai.s_rvalid), 64'h4);
    chk("thr_rready", 64'(ai.m_rready), 64'h1);
    chk("thr_still_blk", 64'(ai.s_arready), 64'h0);
    tick();
    ai.m_rvalid = 1'b0;
    ai.m_rlast = 1'b0;
    #1;
    chk("thr_regrant", 64'(ai.s_arready), 64'h4);
    tick();
    ai.s_arvalid = 4'b0000;
    chk("thr_regrant_id", 64'(ai.m_arid), 64'h2_00A2);
    tick();

    // R routing with back-pressure on requester 3
    do_reset();
    ai.m_arready = 1'b1;
    ai.s_arvalid = 4'b1000;
    tick();
    ai.s_arvalid = 4'b0000;
    tick();
    chk("rr_outst_pre", 64'(dut_a.outst_q[3]), 64'h1);
    ai.m_rvalid = 1'b1;
    ai.m_rid = {2'd3, 16'h00AB};
    ai.m_rdata = 64'hDEAD_BEEF_0123_4567;
    ai.m_rresp = 2'd2;
    ai.m_rlast = 1'b1;
    ai.s_rready = 4'b0000;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("rr_svalid", 64'(ai.s_rvalid), 64'h8);
      chk("rr_sid",    64'(ai.s_rid),    64'h00AB);
      chk("rr_mready", 64'(ai.m_rready), 64'h0);
      tick();
      chk("rr_outst_hold", 64'(dut_a.outst_q[3]), 64'h1);
    end
    chk("rr_sdata", 64'(ai.s_rdata), 64'hDEAD_BEEF_0123_4567);
    chk("rr_sresp", 64'(ai.s_rresp), 64'h2);
    chk("rr_slast", 64'(ai.s_rlast), 64'h1);
    ai.s_rready = 4'b1000;
    #1;
    chk("rr_mready_go", 64'(ai.m_rready), 64'h1);
    tick();
    ai.m_rvalid = 1'b0;
    chk("rr_outst_dec", 64'(dut_a.outst_q[3]), 64'h0);

    // Simultaneous accept and rlast on requester 0; unknown index (B, 3 requesters)
    do_reset();
    bi.m_arready = 1'b1;
    bi.s_arvalid = 3'b001;
    tick();
    bi.s_arvalid = 3'b000;
    tick();
    chk("sim_outst_pre", 64'(dut_b.outst_q[0]), 64'h1);
    bi.s_arvalid = 3'b001;
    bi.m_rvalid = 1'b1;
    bi.m_rid = {2'd0, 16'h0005};
    bi.m_rlast = 1'b1;
    bi.s_rready = 3'b001;
    #1;
    chk("sim_accept", 64'(bi.s_arready), 64'h1);
    chk("sim_rvalid", 64'(bi.s_rvalid), 64'h1);
    chk("sim_rready", 64'(bi.m_rready), 64'h1);
    tick();
    bi.s_arvalid = 3'b000;
    bi.m_rvalid = 1'b0;
    chk("sim_outst_same", 64'(dut_b.outst_q[0]), 64'h1);
    tick();
    bi.m_rvalid = 1'b1;
    bi.m_rid = {2'd3, 16'h0000};
    bi.s_rready = 3'b000;
    #1;
    chk("bad_mready", 64'(bi.m_rready), 64'h1);
    chk("bad_svalid", 64'(bi.s_rvalid), 64'h0);
    chk("bad_pre", 64'(bi.bad_rid), 64'h0);
    tick();
    bi.m_rvalid = 1'b0;
    chk("bad_pulse", 64'(bi.bad_rid), 64'h1);
    tick();
    chk("bad_done", 64'(bi.bad_rid), 64'h0);

    // Reset while the master AR is stalled in HOLD
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ai.s_arid[i*16 +: 16] = 16'h00A0 + 16'(i);
    end
    ai.m_arready = 1'b0;
    ai.s_arvalid = 4'b0100;
    tick();
    ai.s_arvalid = 4'b0000;
    chk("rh_valid", 64'(ai.m_arvalid), 64'h1);
    chk("rh_outst", 64'(dut_a.outst_q[2]), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rh_drop", 64'(ai.m_arvalid), 64'h0);
    chk("rh_outst_clr", 64'(dut_a.outst_q[2]), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ai.s_arvalid = 4'b1111;
    ai.m_arready = 1'b1;
    ai.m_rvalid = 1'b1;
    ai.m_rid = {2'd1, 16'h0011};
    ai.m_rlast = 1'b1;
    ai.s_rready = 4'b0010;
    #1;
    chk("rh_first", 64'(ai.s_arready), 64'h1);
    chk("rh_rroute", 64'(ai.s_rvalid), 64'h2);
    chk("rh_rready", 64'(ai.m_rready), 64'h1);
    tick();
    ai.s_arvalid = 4'b0000;
    ai.m_rvalid = 1'b0;
    chk("rh_sat", 64'(dut_a.outst_q[1]), 64'h0);
    chk("rh_inc", 64'(dut_a.outst_q[0]), 64'h1);
    chk("rh_id", 64'(ai.m_arid), 64'h0_00A0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_ar_norm_arb.md
Name: axi_ar_norm_arb

Overview:
- Shares one downstream AXI4 read port between NUM_REQ upstream read requesters, for example per-tile or per-chip bridges.
- Arbitrates AR requests round-robin and applies the team's standard address normalization to the granted address.
- Extends ARID with the source index, registers the result onto the master port, and routes R beats back by that index.
- Throttles each requester with its own outstanding-burst counter.

Parameters:
- NUM_REQ, 4: number of upstream requesters (2..16).
- IDX_W, $clog2(NUM_REQ): width of the source-index field; derived, do not override.
- MAX_OUTST, 8: maximum outstanding AR bursts per requester (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_arvalid  in  NUM_REQ  per-requester AR valid.
- s_arready  out  NUM_REQ  per-requester AR ready; one-hot or zero.
- s_araddr  in  NUM_REQ*`AXI4_ADDR_WIDTH  packed addresses; requester i occupies slice i.
- s_arid  in  NUM_REQ*`AXI4_ID_WIDTH  packed IDs.
- s_arlen  in  NUM_REQ*`AXI4_LEN_WIDTH  packed burst lengths.
- m_arvalid  out  1  registered AR valid.
- m_arready  in  1  downstream AR ready.
- m_araddr  out  `AXI4_ADDR_WIDTH  normalized address.
- m_arid  out  `AXI4_ID_WIDTH+IDX_W  {source index, original ARID}.
- m_arlen  out  `AXI4_LEN_WIDTH  burst length, passed through.
- m_rvalid  in  1  downstream R valid.
- m_rready  out  1  downstream R ready.
- m_rid  in  `AXI4_ID_WIDTH+IDX_W  returning ID.
- m_rdata  in  `AXI4_DATA_WIDTH  read data.
- m_rresp  in  2  read response.
- m_rlast  in  1  last beat of burst.
- s_rvalid  out  NUM_REQ  per-requester R valid; one-hot or zero.
- s_rready  in  NUM_REQ  per-requester R ready.
- s_rid  out  `AXI4_ID_WIDTH  m_rid with the index field stripped, broadcast to all requesters.
- s_rdata  out  `AXI4_DATA_WIDTH  broadcast.
- s_rresp  out  2  broadcast.
- s_rlast  out  1  broadcast.
- bad_rid  out  1  one-cycle pulse when an R beat arrives with an index >= NUM_REQ.

Behaviour:
- Reset values: state=IDLE; m_arvalid=0; m_araddr/m_arid/m_arlen=0; rr_ptr=0; all outstanding counters=0; bad_rid=0.
- Normalization: out = {in[63:49], in[20:16], in[43:0]}, assuming `AXI4_ADDR_WIDTH=64.
  - Bits 48:44 of the output take node bits 20:16 of the input.
  - Input bits 48:44 are discarded.
- Eligibility: eligible[i] = s_arvalid[i] && (outst[i] < MAX_OUTST).
- FSM IDLE:
  - If any requester is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Drive s_arready[g]=1 combinationally in that cycle. This is the accept.
  - At the clock edge, load the m_ar* registers from slice g with normalization applied, set m_arid={g, s_arid[g]} and m_arvalid=1, and go to HOLD.
  - If no requester is eligible, s_arready=0 and the FSM stays in IDLE.
- FSM HOLD:
  - s_arready=0 throughout.
  - m_ar* stay stable while m_arvalid=1 && !m_arready.
  - On m_arready: m_arvalid becomes 0 the next cycle, rr_ptr=(g+1) mod NUM_REQ, FSM returns to IDLE.
  - Peak rate is one AR every 2 cycles; AR latency is 1 cycle from accept to m_arvalid.
- Outstanding counters:
  - outst[g] increments on an upstream AR accept.
  - outst[k] decrements on an R handshake with m_rlast=1 for index k.
  - A simultaneous increment and decrement on the same counter leaves it unchanged.
  - A decrement at 0 holds at 0 (no underflow).
  - Counters never exceed MAX_OUTST.
- R path (purely combinational, zero latency):
  - k = m_rid[top IDX_W bits].
  - If k < NUM_REQ: s_rvalid[k]=m_rvalid and m_rready=s_rready[k].
  - If k >= NUM_REQ: m_rready=1, the beat is sunk, all s_rvalid=0, and bad_rid pulses for each such beat.
- AR and R paths are independent; an R return never blocks AR arbitration.
- Reset asserted mid-burst: all state clears immediately, and any pending m_arvalid drops.
  - R beats that arrive after reset are still routed by index.
  - Their counter decrements saturate at 0.

Decomposition:
- `AXI4_ADDR_WIDTH, `AXI4_ID_WIDTH, `AXI4_LEN_WIDTH and `AXI4_DATA_WIDTH come from the shared axi_defines.vh.
- Add `AXI4_NODE_LO=16, `AXI4_NODE_HI=20, `AXI4_NODE_DST_LO=44 and `AXI4_NODE_DST_HI=48 there, so every normalization site shares one definition.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr[IDX_W].
  - Outputs: gnt_idx[IDX_W], gnt_vld.
  - Reusable for a future AW-channel twin.

Test Plan:
- Single AR: requester 1 sends araddr=0x0000_1234_5678_0000 (bits 20:16=0x18), arid=0x3 -> one cycle later m_arvalid=1, m_araddr=0x0001_8234_5678_0000, m_arid={2'd1,16'h0003}; stable under 3 cycles of m_arready=0.
- Fairness: all 4 requesters hold s_arvalid=1, m_arready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles.
- Throttle (MAX_OUTST=2): requester 2 issues 2 ARs with no R returns -> third request is never granted and other requesters proceed; one rlast beat with index 2 -> requester 2 is granted within 2 cycles.
- R routing: m_rid={2'd3,16'h00AB}, rlast=1, s_rready[3]=0 for 2 cycles -> only s_rvalid[3]=1, s_rid=0x00AB, m_rready=0 until s_rready[3]=1, then outst[3] decrements.
- Simultaneous events (NUM_REQ=3): AR accept and rlast handshake on requester 0 in the same cycle -> outst[0] unchanged; a beat with index 3 -> m_rready=1 and bad_rid pulses once.
- Reset in HOLD: assert rst while m_arvalid=1, m_arready=0 -> m_arvalid=0 immediately, counters 0; after release, requester 0 is granted first.
